// File: rtl/meter_pkg.sv
// Shared constants for the parking-meter button front end: button indices,
// arbitration priority order and debounce state encodings.
package meter_pkg;

  localparam int NUM_BTN  = 6;

  localparam int BTN_ADD1 = 0;
  localparam int BTN_ADD2 = 1;
  localparam int BTN_ADD3 = 2;
  localparam int BTN_ADD4 = 3;
  localparam int BTN_RST1 = 4;
  localparam int BTN_RST2 = 5;

  // Entry 0 is the highest priority; presets beat the coin-add buttons.
  localparam int PRIO_ORDER [NUM_BTN] = '{BTN_RST2, BTN_RST1, BTN_ADD4,
                                          BTN_ADD3, BTN_ADD2, BTN_ADD1};

  typedef enum logic {
    ST_LO = 1'b0,
    ST_HI = 1'b1
  } db_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Single-button conditioner: two-flop synchronizer followed by a counting
// debounce FSM. level_o only changes after DEBOUNCE_CYCLES consecutive
// synchronized samples that disagree with the current level.
module btn_debounce
  import meter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic       s1_q, s2_q;
  db_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Bring the asynchronous raw button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_i;
      s2_q <= s1_q;
    end
  end

  // Debounce state and run-length counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Count samples that disagree with the current level; any agreeing sample
  // restarts the run so bounces never accumulate.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      ST_LO: begin
        if (s2_q) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_HI;
            cnt_d   = '0;
          end else begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          end
        end
      end
      ST_HI: begin
        if (!s2_q) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_LO;
            cnt_d   = '0;
          end else begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_LO;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_o = (state_q == ST_HI);

endmodule

// File: rtl/meter_button_conditioner.sv
// Front end for the parking-meter core: debounces six buttons, turns each
// press into a single rising-edge event and lets at most one event per clock
// through to the core, flagging any that lost arbitration.
module meter_button_conditioner
  import meter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int CNT_W           = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic               add1_p,
  output logic               add2_p,
  output logic               add3_p,
  output logic               add4_p,
  output logic               rst1_p,
  output logic               rst2_p,
  output logic [NUM_BTN-1:0] btn_level,
  output logic               drop_p
);

  logic [NUM_BTN-1:0] level_w;
  logic [NUM_BTN-1:0] level_q;
  logic [NUM_BTN-1:0] rise_w;
  logic [NUM_BTN-1:0] cmd_q, cmd_d;
  logic               drop_q, drop_d;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_i   (btn_raw[g]),
      .level_o (level_w[g])
    );
  end

  assign rise_w = level_w & ~level_q;

  // Pick the single highest-priority rising edge; walking from lowest to
  // highest priority lets the winner overwrite earlier candidates.
  always_comb begin
    cmd_d = '0;
    for (int k = NUM_BTN - 1; k >= 0; k--) begin
      if (rise_w[PRIO_ORDER[k]]) begin
        cmd_d = '0;
        cmd_d[PRIO_ORDER[k]] = 1'b1;
      end
    end
    drop_d = |(rise_w & ~cmd_d);
  end

  // Previous-level memory for edge detection plus the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      cmd_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      level_q <= level_w;
      cmd_q   <= cmd_d;
      drop_q  <= drop_d;
    end
  end

  assign add1_p    = cmd_q[BTN_ADD1];
  assign add2_p    = cmd_q[BTN_ADD2];
  assign add3_p    = cmd_q[BTN_ADD3];
  assign add4_p    = cmd_q[BTN_ADD4];
  assign rst1_p    = cmd_q[BTN_RST1];
  assign rst2_p    = cmd_q[BTN_RST2];
  assign btn_level = level_w;
  assign drop_p    = drop_q;

endmodule

// File: tb/tb_meter_button_conditioner.sv
// Bench for meter_button_conditioner: directed button sequences push the
// pulses they should cause into a queue; a monitor pops them as the DUT
// emits pulses and reports anything early, late, wrong or unexpected.
module tb_meter_button_conditioner;

  typedef struct {
    int         cyc;
    logic [5:0] pulses;
    logic       drop;
  } expItem_t;

  logic       clk;
  logic       rst_n;
  logic [5:0] btn_raw;
  logic       add1_p, add2_p, add3_p, add4_p, rst1_p, rst2_p;
  logic [5:0] btn_level;
  logic       drop_p;

  expItem_t   expQ[$];
  int         cyc;
  int         compared;
  int         mismatched;
  logic [5:0] outVec;

  meter_button_conditioner #(
    .DEBOUNCE_CYCLES (3),
    .CNT_W           (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .add1_p    (add1_p),
    .add2_p    (add2_p),
    .add3_p    (add3_p),
    .add4_p    (add4_p),
    .rst1_p    (rst1_p),
    .rst2_p    (rst2_p),
    .btn_level (btn_level),
    .drop_p    (drop_p)
  );

  assign outVec = {rst2_p, rst1_p, add4_p, add3_p, add2_p, add1_p};

  // 100 Hz is irrelevant to logic; any period works.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges so expectations can name the cycle of a pulse.
  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared = compared + 1;
    if (actual !== expected) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  // Drive a new raw button vector just after a falling edge.
  task automatic applyStimulus(input logic [5:0] v);
    @(negedge clk);
    btn_raw = v;
  endtask

  task automatic expectPulse(input int delay, input logic [5:0] pulses,
                             input logic drop);
    expItem_t it;
    it.cyc    = cyc + delay;
    it.pulses = pulses;
    it.drop   = drop;
    expQ.push_back(it);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
      checkOutput("missed_pulse", 32'(expQ[0].cyc), 32'(cyc));
      void'(expQ.pop_front());
    end
    if (outVec != 6'b0 || drop_p) begin
      if (expQ.size() == 0 || expQ[0].cyc != cyc) begin
        checkOutput("unexpected_pulse", {25'b0, drop_p, outVec}, 32'b0);
      end else begin
        checkOutput("pulse_vector", {26'b0, outVec}, {26'b0, expQ[0].pulses});
        checkOutput("drop_flag", {31'b0, drop_p}, {31'b0, expQ[0].drop});
        void'(expQ.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    btn_raw    = 6'b0;
    rst_n      = 1'b0;
    waitCycles(3);
    checkOutput("reset_level", {26'b0, btn_level}, 32'b0);
    checkOutput("reset_pulses", {25'b0, drop_p, outVec}, 32'b0);
    rst_n = 1'b1;

    // Idle after reset: nothing should ever fire.
    for (int i = 0; i < 5; i++) begin
      waitCycles(10);
      checkOutput("idle_level", {26'b0, btn_level}, 32'b0);
    end

    // Clean press held 20 cycles: one add1 pulse, six cycles later.
    applyStimulus(6'b000001);
    expectPulse(6, 6'b000001, 1'b0);
    waitCycles(20);
    checkOutput("held_level", {26'b0, btn_level}, 32'h01);
    applyStimulus(6'b000000);
    waitCycles(10);
    checkOutput("release_level", {26'b0, btn_level}, 32'b0);

    // Bounce on add3 then steady high.
    applyStimulus(6'b000100);
    applyStimulus(6'b000000);
    applyStimulus(6'b000100);
    applyStimulus(6'b000000);
    applyStimulus(6'b000100);
    expectPulse(6, 6'b000100, 1'b0);
    waitCycles(3);
    checkOutput("bounce_level_low", {26'b0, btn_level}, 32'b0);
    waitCycles(10);
    checkOutput("bounce_level_high", {26'b0, btn_level}, 32'h04);
    applyStimulus(6'b000000);
    waitCycles(10);

    // add2 and rst2 together: rst2 wins, add2 is dropped.
    applyStimulus(6'b100010);
    expectPulse(6, 6'b100000, 1'b1);
    waitCycles(12);
    checkOutput("simul_level", {26'b0, btn_level}, 32'h22);
    applyStimulus(6'b000000);
    waitCycles(10);

    // Two-cycle glitch on add4 must be filtered.
    applyStimulus(6'b001000);
    waitCycles(1);
    applyStimulus(6'b000000);
    waitCycles(10);
    checkOutput("glitch_level", {26'b0, btn_level}, 32'b0);

    // Reset one cycle before add1 would pulse; it must re-qualify afterwards.
    applyStimulus(6'b000001);
    waitCycles(5);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_level", {26'b0, btn_level}, 32'b0);
    waitCycles(2);
    rst_n = 1'b1;
    expectPulse(6, 6'b000001, 1'b0);
    waitCycles(12);
    checkOutput("requal_level", {26'b0, btn_level}, 32'h01);
    applyStimulus(6'b000000);
    waitCycles(10);

    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
